// File: rtl/adventure_move_controller.sv
`default_nettype none
// adventure_move_controller: turns button presses into arbitrated, rate-limited move
// pulses for the room FSM, tracks item flags and sequences game-over and restart.
module adventure_move_controller #(
    parameter int         COOLDOWN      = 4,
    parameter int         GAMEOVER_HOLD = 8,
    parameter int         MCW           = 8,
    parameter logic [8:0] SWORD_ROOM    = 9'b000001000,
    parameter logic [8:0] WIZARD_ROOM   = 9'b100000000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           btn_n,
    input  logic           btn_s,
    input  logic           btn_e,
    input  logic           btn_w,
    input  logic [8:0]     room,
    input  logic           win_in,
    input  logic           dead_in,
    output logic           n,
    output logic           s,
    output logic           e,
    output logic           w,
    output logic           v,
    output logic           h,
    output logic           game_reset,
    output logic           game_over,
    output logic           busy,
    output logic [MCW-1:0] move_count
);

    localparam int CCW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam int HCW = (GAMEOVER_HOLD > 1) ? $clog2(GAMEOVER_HOLD) : 1;
    localparam logic [CCW-1:0] C_COOL_LOAD = (COOLDOWN > 0) ? CCW'(COOLDOWN - 1) : '0;
    localparam logic [HCW-1:0] C_HOLD_LOAD = (GAMEOVER_HOLD > 0) ? HCW'(GAMEOVER_HOLD - 1) : '0;
    localparam logic [MCW-1:0] C_COUNT_MAX = {MCW{1'b1}};

    typedef enum logic [4:0] {
        S_IDLE    = 5'b00001,
        S_ISSUE   = 5'b00010,
        S_COOL    = 5'b00100,
        S_ENDGAME = 5'b01000,
        S_RESTART = 5'b10000
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     btn, btn_q, press, win_dir;
    logic [3:0]     dir_q, dir_d;
    logic [CCW-1:0] cool_q, cool_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic           primed_q;
    logic           terminal;

    // Bit order throughout is {w, e, s, n}.
    assign btn      = {btn_w, btn_e, btn_s, btn_n};
    assign terminal = win_in | dead_in;

    // The history register is cleared by reset, so the first cycle after reset only
    // captures button levels; a button held through reset must not count as a press.
    assign press = btn & ~btn_q & {4{primed_q}};

    always_comb begin
        win_dir = 4'b0000;
        if (press[0])      win_dir = 4'b0001;
        else if (press[1]) win_dir = 4'b0010;
        else if (press[2]) win_dir = 4'b0100;
        else if (press[3]) win_dir = 4'b1000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            dir_q    <= 4'b0000;
            cool_q   <= '0;
            hold_q   <= '0;
            btn_q    <= 4'b0000;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            cool_q   <= cool_d;
            hold_q   <= hold_d;
            btn_q    <= btn;
            primed_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cool_d  = cool_q;
        hold_d  = hold_q;
        case (state_q)
            S_IDLE: begin
                if (terminal) begin
                    state_d = S_ENDGAME;
                    hold_d  = C_HOLD_LOAD;
                end else if (|press) begin
                    state_d = S_ISSUE;
                    dir_d   = win_dir;
                end
            end
            S_ISSUE: begin
                if (terminal) begin
                    state_d = S_ENDGAME;
                    hold_d  = C_HOLD_LOAD;
                end else if (COOLDOWN > 0) begin
                    state_d = S_COOL;
                    cool_d  = C_COOL_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COOL: begin
                if (terminal) begin
                    state_d = S_ENDGAME;
                    hold_d  = C_HOLD_LOAD;
                end else if (cool_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cool_d = cool_q - CCW'(1);
                end
            end
            S_ENDGAME: begin
                if (hold_q == '0) state_d = S_RESTART;
                else              hold_d  = hold_q - HCW'(1);
            end
            S_RESTART: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Pulses are loaded from the next state so they are flops aligned with ISSUE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {w, e, s, n} <= 4'b0000;
        end else if (state_d == S_ISSUE) begin
            {w, e, s, n} <= dir_d;
        end else begin
            {w, e, s, n} <= 4'b0000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_count <= '0;
            v          <= 1'b0;
            h          <= 1'b0;
        end else if (state_q == S_RESTART) begin
            move_count <= '0;
            v          <= 1'b0;
            h          <= 1'b0;
        end else begin
            if (state_q == S_ISSUE && move_count != C_COUNT_MAX) begin
                move_count <= move_count + MCW'(1);
            end
            if (room == SWORD_ROOM)  v <= 1'b1;
            if (room == WIZARD_ROOM) h <= 1'b1;
        end
    end

    assign game_over  = (state_q == S_ENDGAME);
    assign game_reset = (state_q == S_RESTART);
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire
